// File: rtl/note_articulator.sv
// Note articulator: separates consecutive tone periods either with a silent
// re-articulation gap or with a bounded-step glide (portamento) toward the new note.
module note_articulator #(
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int STEP_CYCLES = 12_500,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] tone_in,
    input  logic        glide_en,
    output logic [23:0] tone_out,
    output logic        busy,
    output logic        note_start
);

    localparam int GW = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic [1:0] {PLAY, GAP, GLIDE} state_t;

    state_t        state, next_state;
    logic [23:0]   tgt, cur, next_cur;
    logic [GW-1:0] gap_cnt, next_gap;
    logic [SW-1:0] step_cnt, next_step;
    logic          next_ns;

    logic          change;
    logic [23:0]   tgt_sel;
    logic [24:0]   diff, mag, shifted, delta;
    logic [23:0]   step_cur;

    assign change  = (tone_in != tgt);
    assign tgt_sel = change ? tone_in : tgt;

    // Glide step uses the freshly accepted target so a same-cycle retarget wins.
    assign diff    = {1'b0, tgt_sel} - {1'b0, cur};
    assign mag     = diff[24] ? (~diff + 25'd1) : diff;
    assign shifted = mag >> GLIDE_SHIFT;
    assign delta   = (mag == 25'd0) ? 25'd0 : ((shifted == 25'd0) ? 25'd1 : shifted);
    assign step_cur = diff[24] ? (cur - delta[23:0]) : (cur + delta[23:0]);

    always_comb begin
        next_state = state;
        next_cur   = cur;
        next_gap   = gap_cnt;
        next_step  = step_cnt;
        next_ns    = 1'b0;
        unique case (state)
            PLAY: begin
                if (change) begin
                    if (tone_in == 24'd0) begin
                        next_cur = 24'd0;
                    end else if (cur == 24'd0) begin
                        next_cur = tone_in;
                        next_ns  = 1'b1;
                    end else if (!glide_en) begin
                        next_cur   = tone_in;
                        next_state = GAP;
                        next_gap   = '0;
                    end else begin
                        next_state = GLIDE;
                        next_step  = '0;
                    end
                end
            end
            GAP: begin
                if (change && tone_in == 24'd0) begin
                    next_cur   = 24'd0;
                    next_state = PLAY;
                end else begin
                    if (change)
                        next_cur = tone_in;
                    next_gap = gap_cnt + GW'(1);
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        next_state = PLAY;
                        next_ns    = 1'b1;
                    end
                end
            end
            GLIDE: begin
                if (change && tone_in == 24'd0) begin
                    next_cur   = 24'd0;
                    next_state = PLAY;
                end else if (step_cnt == SW'(STEP_CYCLES - 1)) begin
                    next_cur  = step_cur;
                    next_step = '0;
                    if (step_cur == tgt_sel)
                        next_state = PLAY;
                end else begin
                    next_step = step_cnt + SW'(1);
                end
            end
            default: next_state = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PLAY;
            tgt        <= 24'd0;
            cur        <= 24'd0;
            gap_cnt    <= '0;
            step_cnt   <= '0;
            tone_out   <= 24'd0;
            busy       <= 1'b0;
            note_start <= 1'b0;
        end else begin
            state      <= next_state;
            tgt        <= tgt_sel;
            cur        <= next_cur;
            gap_cnt    <= next_gap;
            step_cnt   <= next_step;
            tone_out   <= (next_state == GAP) ? 24'd0 : next_cur;
            busy       <= (next_state != PLAY);
            note_start <= next_ns;
        end
    end

endmodule
